// File: rtl/sram_axi_bridge.sv
`default_nettype none
// ==========================================================================
// Module  : sram_axi_bridge
// Brief   : inst/data sram-like channels -> one AXI3 master, single beat,
//           one outstanding. Option macro: SRAM_AXI_BRIDGE_ERR_EN (bus_err).
// Revision: 1.0
// ==========================================================================
module sram_axi_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
`ifdef SRAM_AXI_BRIDGE_ERR_EN
  output logic              bus_err,
`endif
  output logic [3:0]        arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [3:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic [1:0]        arlock,
  output logic [3:0]        arcache,
  output logic [2:0]        arprot,
  output logic              arvalid,
  input  logic              arready,
  input  logic [3:0]        rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic [3:0]        awid,
  output logic [ADDR_W-1:0] awaddr,
  output logic [3:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic [1:0]        awlock,
  output logic [3:0]        awcache,
  output logic [2:0]        awprot,
  output logic              awvalid,
  input  logic              awready,
  output logic [3:0]        wid,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_RESP = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              owner_q, owner_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
  logic [DATA_W-1:0] data_rdata_q, data_rdata_d;

  assign arlen   = 4'd0;
  assign awlen   = 4'd0;
  assign arburst = 2'd1;
  assign awburst = 2'd1;
  assign arlock  = 2'd0;
  assign awlock  = 2'd0;
  assign arcache = 4'd0;
  assign awcache = 4'd0;
  assign arprot  = 3'd0;
  assign awprot  = 3'd0;
  assign awid    = 4'd1;
  assign wid     = 4'd1;
  assign wlast   = 1'b1;

  assign arid   = {3'b000, owner_q};
  assign araddr = addr_q;
  assign arsize = {1'b0, size_q};
  assign awaddr = addr_q;
  assign awsize = {1'b0, size_q};
  assign wdata  = wdata_q;

  always_comb begin
    case (size_q)
      2'd0:    wstrb = 4'b0001 << addr_q[1:0];
      2'd1:    wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
      default: wstrb = 4'b1111;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    size_d       = size_q;
    wdata_d      = wdata_q;
    owner_d      = owner_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    inst_rdata   = inst_rdata_q;
    data_rdata   = data_rdata_q;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    arvalid      = 1'b0;
    rready       = 1'b0;
    awvalid      = 1'b0;
    wvalid       = 1'b0;
    bready       = 1'b0;

    case (state_q)
      S_IDLE: begin
        // addr_ok is gated by resetn so nothing is acknowledged while held in reset
        data_addr_ok = data_req & resetn;
        inst_addr_ok = inst_req & ~data_req & resetn;
        if (data_req) begin
          addr_d    = data_addr;
          size_d    = data_size;
          wdata_d   = data_wdata;
          owner_d   = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = data_wr ? S_WR_REQ : S_RD_ADDR;
        end else if (inst_req) begin
          addr_d  = inst_addr;
          size_d  = inst_size;
          wdata_d = '0;
          owner_d = 1'b0;
          state_d = S_RD_ADDR;
        end
      end
      S_RD_ADDR: begin
        arvalid = 1'b1;
        if (arready) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        rready = 1'b1;
        if (rvalid) begin
          if (owner_q) begin
            data_data_ok = 1'b1;
            data_rdata   = rdata;
            data_rdata_d = rdata;
          end else begin
            inst_data_ok = 1'b1;
            inst_rdata   = rdata;
            inst_rdata_d = rdata;
          end
          state_d = S_IDLE;
        end
      end
      S_WR_REQ: begin
        awvalid   = ~aw_done_q;
        wvalid    = ~w_done_q;
        aw_done_d = aw_done_q | awready;
        w_done_d  = w_done_q | wready;
        if (aw_done_d && w_done_d) state_d = S_WR_RESP;
      end
      S_WR_RESP: begin
        bready = 1'b1;
        if (bvalid) begin
          data_data_ok = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      size_q       <= '0;
      wdata_q      <= '0;
      owner_q      <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      wdata_q      <= wdata_d;
      owner_q      <= owner_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

`ifdef SRAM_AXI_BRIDGE_ERR_EN
  logic bus_err_q, bus_err_d;
  assign bus_err = bus_err_q;

  always_comb begin
    bus_err_d = bus_err_q | (rready & rvalid & (|rresp)) | (bready & bvalid & (|bresp));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) bus_err_q <= 1'b0;
    else         bus_err_q <= bus_err_d;
  end

  logic w_unused_ok;
  assign w_unused_ok = ^{inst_wr, inst_wdata, rid, rlast};
`else
  logic w_unused_ok;
  assign w_unused_ok = ^{inst_wr, inst_wdata, rid, rlast, rresp, bresp};
`endif

endmodule
`default_nettype wire
